// File: rtl/rob_retire_ctl.sv
// In-order retirement controller for the reorder buffer.
//
// Each cycle the controller scans the ROB head window and retires the longest
// prefix of entries that are complete, do not raise an exception, are not
// stores, and fit within the available register-file write ports. Stores are
// committed one at a time through a request/acknowledge handshake with the
// store buffer. An excepting head entry stops retirement, pulses exc_flush,
// and waits for exc_clear.
//
// Ports:
//   clock, reset_n       clock and asynchronous active-low reset
//   slot_*               head-window entry attributes, index 0 is the ROB head
//   rob_used_count       number of occupied ROB entries
//   consume              retire this cycle (combinational, sampled by the ROB)
//   consume_count        number of entries retired minus one
//   rf_we/waddr/wdata    architectural register-file write ports
//   st_commit            registered request to commit the head store
//   st_commit_ack        store buffer accepted the commit
//   exc_flush            registered one-cycle pulse on exception at head
//   exc_clear            exception handled, resume retirement
//   retire_total         running count of retired instructions (wraps)
module rob_retire_ctl #(
  parameter int unsigned EXT_COUNT    = 4,
  parameter int unsigned RF_PORTS     = 2,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DEPTHLOG2    = $clog2(DEPTH),
  parameter int unsigned EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [EXT_COUNT-1:0]               slot_valid,
  input  logic [EXT_COUNT-1:0][4:0]          slot_dest_reg,
  input  logic [EXT_COUNT-1:0]               slot_dest_valid,
  input  logic [EXT_COUNT-1:0][31:0]         slot_result,
  input  logic [EXT_COUNT-1:0]               slot_is_store,
  input  logic [EXT_COUNT-1:0]               slot_exc,
  input  logic [DEPTHLOG2:0]                 rob_used_count,
  output logic                               consume,
  output logic [EXTCOUNTLOG2-1:0]            consume_count,
  output logic [RF_PORTS-1:0]                rf_we,
  output logic [RF_PORTS-1:0][4:0]           rf_waddr,
  output logic [RF_PORTS-1:0][31:0]          rf_wdata,
  output logic                               st_commit,
  input  logic                               st_commit_ack,
  output logic                               exc_flush,
  input  logic                               exc_clear,
  output logic [31:0]                        retire_total
);

  // Width of the retire count, wide enough to hold EXT_COUNT itself.
  localparam int unsigned NW = EXTCOUNTLOG2 + 1;

  typedef enum logic [1:0] {
    StRun,
    StStWait,
    StExcWait
  } state_e;

  state_e      state_q, state_d;
  logic        st_commit_q, st_commit_d;
  logic        exc_flush_q, exc_flush_d;
  logic [31:0] retire_total_q, retire_total_d;

  // Result of the head-window prefix scan.
  logic [NW-1:0]             scan_n;
  logic [RF_PORTS-1:0]       scan_we;
  logic [RF_PORTS-1:0][4:0]  scan_waddr;
  logic [RF_PORTS-1:0][31:0] scan_wdata;

  // Ungated combinational outputs; forced to zero below while in reset.
  logic                      consume_c;
  logic [EXTCOUNTLOG2-1:0]   count_c;
  logic [RF_PORTS-1:0]       we_c;
  logic [RF_PORTS-1:0][4:0]  waddr_c;
  logic [RF_PORTS-1:0][31:0] wdata_c;

  logic head_real_wr;
  logic head_in_window;

  assign head_real_wr   = slot_dest_valid[0] && (slot_dest_reg[0] != 5'd0);
  assign head_in_window = (rob_used_count != '0);

  // Longest retirable prefix. Register-0 writes do not occupy a port, so the
  // port index advances only on real writes.
  always_comb begin : prefix_scan
    int   n_v;
    int   used_v;
    logic stop_v;
    logic real_v;
    n_v        = 0;
    used_v     = 0;
    stop_v     = 1'b0;
    real_v     = 1'b0;
    scan_we    = '0;
    scan_waddr = '0;
    scan_wdata = '0;
    for (int i = 0; i < int'(EXT_COUNT); i++) begin
      real_v = slot_dest_valid[i] && (slot_dest_reg[i] != 5'd0);
      if (!stop_v) begin
        if ((i >= int'(rob_used_count)) || !slot_valid[i] || slot_exc[i] ||
            slot_is_store[i] || (real_v && (used_v >= int'(RF_PORTS)))) begin
          stop_v = 1'b1;
        end else begin
          for (int p = 0; p < int'(RF_PORTS); p++) begin
            if (real_v && (p == used_v)) begin
              scan_we[p]    = 1'b1;
              scan_waddr[p] = slot_dest_reg[i];
              scan_wdata[p] = slot_result[i];
            end
          end
          if (real_v) begin
            used_v = used_v + 1;
          end
          n_v = n_v + 1;
        end
      end
    end
    scan_n = NW'(n_v);
  end

  always_comb begin : next_state
    state_d        = state_q;
    st_commit_d    = st_commit_q;
    exc_flush_d    = 1'b0;
    retire_total_d = retire_total_q;
    consume_c      = 1'b0;
    count_c        = '0;
    we_c           = '0;
    waddr_c        = '0;
    wdata_c        = '0;

    unique case (state_q)
      StRun: begin
        if (scan_n != '0) begin
          consume_c      = 1'b1;
          count_c        = EXTCOUNTLOG2'(scan_n - NW'(1));
          we_c           = scan_we;
          waddr_c        = scan_waddr;
          wdata_c        = scan_wdata;
          retire_total_d = retire_total_q + 32'(scan_n);
        end else if (head_in_window && slot_valid[0]) begin
          // Exception wins over a store in the same entry.
          if (slot_exc[0]) begin
            exc_flush_d = 1'b1;
            state_d     = StExcWait;
          end else if (slot_is_store[0]) begin
            st_commit_d = 1'b1;
            state_d     = StStWait;
          end
        end
      end

      StStWait: begin
        if (st_commit_ack) begin
          consume_c      = 1'b1;
          count_c        = '0;
          if (head_real_wr) begin
            we_c[0]    = 1'b1;
            waddr_c[0] = slot_dest_reg[0];
            wdata_c[0] = slot_result[0];
          end
          retire_total_d = retire_total_q + 32'd1;
          st_commit_d    = 1'b0;
          state_d        = StRun;
        end
      end

      StExcWait: begin
        if (exc_clear) begin
          state_d = StRun;
        end
      end

      default: begin
        state_d     = StRun;
        st_commit_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StRun;
      st_commit_q    <= 1'b0;
      exc_flush_q    <= 1'b0;
      retire_total_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      st_commit_q    <= st_commit_d;
      exc_flush_q    <= exc_flush_d;
      retire_total_q <= retire_total_d;
    end
  end

  always_comb begin : out_gate
    consume       = reset_n & consume_c;
    consume_count = reset_n ? count_c : '0;
    rf_we         = reset_n ? we_c    : '0;
    rf_waddr      = reset_n ? waddr_c : '0;
    rf_wdata      = reset_n ? wdata_c : '0;
  end

  assign st_commit    = st_commit_q;
  assign exc_flush    = exc_flush_q;
  assign retire_total = retire_total_q;

endmodule

// File: tb/tb_rob_retire_ctl.sv
module tb_rob_retire_ctl;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [3:0]        slot_valid;
  logic [3:0][4:0]   slot_dest_reg;
  logic [3:0]        slot_dest_valid;
  logic [3:0][31:0]  slot_result;
  logic [3:0]        slot_is_store;
  logic [3:0]        slot_exc;
  logic [4:0]        rob_used_count;
  logic              consume;
  logic [1:0]        consume_count;
  logic [1:0]        rf_we;
  logic [1:0][4:0]   rf_waddr;
  logic [1:0][31:0]  rf_wdata;
  logic              st_commit;
  logic              st_commit_ack;
  logic              exc_flush;
  logic              exc_clear;
  logic [31:0]       retire_total;

  always #5 clock = ~clock;

  rob_retire_ctl #(
    .EXT_COUNT(4),
    .RF_PORTS (2),
    .DEPTH    (16)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .slot_valid     (slot_valid),
    .slot_dest_reg  (slot_dest_reg),
    .slot_dest_valid(slot_dest_valid),
    .slot_result    (slot_result),
    .slot_is_store  (slot_is_store),
    .slot_exc       (slot_exc),
    .rob_used_count (rob_used_count),
    .consume        (consume),
    .consume_count  (consume_count),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .st_commit      (st_commit),
    .st_commit_ack  (st_commit_ack),
    .exc_flush      (exc_flush),
    .exc_clear      (exc_clear),
    .retire_total   (retire_total)
  );

  typedef struct {
    logic [1:0]  cnt;
    logic [1:0]  we;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] c, input logic [1:0] we,
                      input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1);
    exp_t e;
    e.cnt = c;
    e.we  = we;
    e.a0  = a0;
    e.d0  = d0;
    e.a1  = a1;
    e.d1  = d1;
    exp_q.push_back(e);
  endtask

  // Monitor: every retirement the DUT presents must match the next expectation.
  always @(negedge clock) begin
    exp_t e;
    if (consume === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_consume", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("consume_count", 32'(consume_count), 32'(e.cnt));
        chk("rf_we", 32'(rf_we), 32'(e.we));
        if (e.we[0]) begin
          chk("rf_waddr0", 32'(rf_waddr[0]), 32'(e.a0));
          chk("rf_wdata0", rf_wdata[0], e.d0);
        end
        if (e.we[1]) begin
          chk("rf_waddr1", 32'(rf_waddr[1]), 32'(e.a1));
          chk("rf_wdata1", rf_wdata[1], e.d1);
        end
      end
    end
  end

  task automatic clear_slots();
    slot_valid      = '0;
    slot_dest_reg   = '0;
    slot_dest_valid = '0;
    slot_result     = '0;
    slot_is_store   = '0;
    slot_exc        = '0;
    rob_used_count  = 5'd0;
  endtask

  task automatic set_slot(input logic [1:0] i, input logic st, input logic ex,
                          input logic dv, input logic [4:0] r, input logic [31:0] d);
    slot_valid[i]      = 1'b1;
    slot_is_store[i]   = st;
    slot_exc[i]        = ex;
    slot_dest_valid[i] = dv;
    slot_dest_reg[i]   = r;
    slot_result[i]     = d;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    st_commit_ack = 1'b0;
    exc_clear     = 1'b0;
    clear_slots();
    // Retirable entries present during reset must not be consumed.
    set_slot(2'd0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11);
    set_slot(2'd1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h22);
    rob_used_count = 5'd4;
    #12;
    chk("reset_consume", 32'(consume), 32'd0);
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_count", 32'(consume_count), 32'd0);
    chk("reset_st_commit", 32'(st_commit), 32'd0);
    chk("reset_exc_flush", 32'(exc_flush), 32'd0);
    chk("reset_retire_total", retire_total, 32'd0);
    clear_slots();
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // Four ALU ops r1..r4: port limit splits them over two cycles.
    set_slot(2'd0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h1001);
    set_slot(2'd1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h1002);
    set_slot(2'd2, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1003);
    set_slot(2'd3, 1'b0, 1'b0, 1'b1, 5'd4, 32'h1004);
    rob_used_count = 5'd4;
    push(2'd1, 2'b11, 5'd1, 32'h1001, 5'd2, 32'h1002);
    step();
    clear_slots();
    set_slot(2'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1003);
    set_slot(2'd1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h1004);
    rob_used_count = 5'd2;
    push(2'd1, 2'b11, 5'd3, 32'h1003, 5'd4, 32'h1004);
    step();
    clear_slots();
    chk("total_after_t1", retire_total, 32'd4);

    // Empty ROB: valid slot data is ignored.
    set_slot(2'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h77);
    rob_used_count = 5'd0;
    mid();
    chk("empty_consume", 32'(consume), 32'd0);
    step();
    clear_slots();

    // Valid pattern 1,0,1,1: only slot 0 retires.
    set_slot(2'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h55);
    set_slot(2'd2, 1'b0, 1'b0, 1'b1, 5'd7, 32'h77);
    set_slot(2'd3, 1'b0, 1'b0, 1'b1, 5'd8, 32'h88);
    rob_used_count = 5'd4;
    push(2'd0, 2'b01, 5'd5, 32'h55, 5'd0, 32'h0);
    step();
    clear_slots();
    chk("total_after_t2", retire_total, 32'd5);

    // r0 write, no-dest, r5, r0: all four retire with a single write.
    set_slot(2'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hA0);
    set_slot(2'd1, 1'b0, 1'b0, 1'b0, 5'd9, 32'hA1);
    set_slot(2'd2, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA2);
    set_slot(2'd3, 1'b0, 1'b0, 1'b1, 5'd0, 32'hA3);
    rob_used_count = 5'd4;
    push(2'd3, 2'b01, 5'd5, 32'hA2, 5'd0, 32'h0);
    step();
    clear_slots();
    chk("total_after_t3", retire_total, 32'd9);

    // Store at slot 2 behind two ALU ops.
    set_slot(2'd0, 1'b0, 1'b0, 1'b1, 5'd10, 32'hB0);
    set_slot(2'd1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hB1);
    set_slot(2'd2, 1'b1, 1'b0, 1'b1, 5'd12, 32'hAAAA);
    set_slot(2'd3, 1'b0, 1'b0, 1'b1, 5'd11, 32'hB3);
    rob_used_count = 5'd4;
    push(2'd1, 2'b01, 5'd10, 32'hB0, 5'd0, 32'h0);
    step();
    clear_slots();
    set_slot(2'd0, 1'b1, 1'b0, 1'b1, 5'd12, 32'hAAAA);
    set_slot(2'd1, 1'b0, 1'b0, 1'b1, 5'd11, 32'hB3);
    rob_used_count = 5'd2;
    mid();
    chk("st_commit_not_yet", 32'(st_commit), 32'd0);
    chk("total_after_t4a", retire_total, 32'd11);
    step();
    chk("st_commit_rise", 32'(st_commit), 32'd1);
    step();
    chk("st_commit_hold1", 32'(st_commit), 32'd1);
    step();
    chk("st_commit_hold2", 32'(st_commit), 32'd1);
    st_commit_ack = 1'b1;
    push(2'd0, 2'b01, 5'd12, 32'hAAAA, 5'd0, 32'h0);
    step();
    clear_slots();
    chk("st_commit_fall", 32'(st_commit), 32'd0);
    chk("total_after_store", retire_total, 32'd12);
    // Ack while in RUN has no effect.
    step();
    st_commit_ack = 1'b0;
    chk("ack_in_run_total", retire_total, 32'd12);
    chk("ack_in_run_st_commit", 32'(st_commit), 32'd0);

    // Exception at head, same entry also a store: exception wins.
    set_slot(2'd0, 1'b1, 1'b1, 1'b1, 5'd3, 32'hC0);
    set_slot(2'd1, 1'b0, 1'b0, 1'b1, 5'd4, 32'hC1);
    set_slot(2'd2, 1'b0, 1'b0, 1'b1, 5'd5, 32'hC2);
    set_slot(2'd3, 1'b0, 1'b0, 1'b1, 5'd6, 32'hC3);
    rob_used_count = 5'd4;
    mid();
    chk("exc_cycle_consume", 32'(consume), 32'd0);
    chk("exc_flush_registered", 32'(exc_flush), 32'd0);
    step();
    chk("exc_flush_pulse", 32'(exc_flush), 32'd1);
    chk("exc_no_st_commit", 32'(st_commit), 32'd0);
    step();
    chk("exc_flush_one_cycle", 32'(exc_flush), 32'd0);
    for (int k = 0; k < 9; k++) begin
      mid();
      chk("exc_wait_consume", 32'(consume), 32'd0);
      step();
    end
    exc_clear = 1'b1;
    mid();
    chk("exc_clear_cycle_consume", 32'(consume), 32'd0);
    step();
    exc_clear = 1'b0;
    chk("exc_flush_after_clear", 32'(exc_flush), 32'd0);

    // Resume with rob_used_count=1 and four valid slots: window of one.
    clear_slots();
    set_slot(2'd0, 1'b0, 1'b0, 1'b1, 5'd1, 32'hD1);
    set_slot(2'd1, 1'b0, 1'b0, 1'b1, 5'd2, 32'hD2);
    set_slot(2'd2, 1'b0, 1'b0, 1'b1, 5'd3, 32'hD3);
    set_slot(2'd3, 1'b0, 1'b0, 1'b1, 5'd4, 32'hD4);
    rob_used_count = 5'd1;
    push(2'd0, 2'b01, 5'd1, 32'hD1, 5'd0, 32'h0);
    step();
    clear_slots();
    chk("total_after_resume", retire_total, 32'd13);

    // Reset while waiting for a store ack.
    set_slot(2'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'hE0);
    rob_used_count = 5'd1;
    step();
    chk("st_wait_entered", 32'(st_commit), 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("reset_mid_st_commit", 32'(st_commit), 32'd0);
    chk("reset_mid_total", retire_total, 32'd0);
    chk("reset_mid_consume", 32'(consume), 32'd0);
    clear_slots();
    @(negedge clock);
    reset_n = 1'b1;
    step();
    set_slot(2'd0, 1'b0, 1'b0, 1'b1, 5'd6, 32'hF6);
    rob_used_count = 5'd1;
    push(2'd0, 2'b01, 5'd6, 32'hF6, 5'd0, 32'h0);
    step();
    clear_slots();
    chk("total_after_reset", retire_total, 32'd1);
    chk("st_commit_after_reset", 32'(st_commit), 32'd0);

    step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
